// File: rtl/crc_stream_pkg.sv
// rtl/crc_stream_pkg.sv - shared types and width helper for the CRC transmit stream
package crc_stream_pkg;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } state_t;

    // Ceiling log2 for sizing pointers and counters; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO
//
// Ports: clk/rst_n (async active-low); push/wdata write side;
// pop/rdata read side (rdata is the head entry whenever !empty);
// full/empty/count occupancy status.
module sync_fifo_fwft
    import crc_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Protect the storage even if a caller ignores full/empty.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/crc_tx_append.sv
// rtl/crc_tx_append.sv - forwards frames to a CRC generator and re-emits them with the CRC appended
//
// Ports: s_* framed input stream; crc_din/crc_dlast/crc_flitEn feed the
// generator; crc_in/crc_in_vld collect its results; m_* output stream with
// one CRC beat (m_last=m_is_crc=1) after each frame; crc_err flags an
// unsolicited CRC and stays set until reset.
module crc_tx_append
    import crc_stream_pkg::*;
#(
    parameter int DWIDTH      = 512,
    parameter int CRC_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int CRC_Q_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DWIDTH-1:0]    s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [DWIDTH-1:0]    crc_din,
    output logic                 crc_dlast,
    output logic                 crc_flitEn,
    input  logic [CRC_WIDTH-1:0] crc_in,
    input  logic                 crc_in_vld,
    output logic [DWIDTH-1:0]    m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 m_is_crc,
    output logic                 crc_err
);

    localparam int PW  = clog2(CRC_Q_DEPTH) + 1;
    localparam int DCW = clog2(FIFO_DEPTH) + 1;

    state_t               state;
    state_t               state_next;
    logic [PW-1:0]        pend_cnt;
    logic                 accept;

    logic                 d_full;
    logic                 d_empty;
    logic                 d_pop;
    logic                 d_head_last;
    logic [DWIDTH-1:0]    d_head_data;
    logic [DCW-1:0]       d_count;

    logic                 q_full;
    logic                 q_empty;
    logic                 q_push;
    logic                 q_pop;
    logic [CRC_WIDTH-1:0] q_head;
    logic [PW-1:0]        q_count;
    logic                 unsolicited;

    // Data FIFO occupancy is only needed through full/empty.
    logic                 unused_status;
    assign unused_status = ^d_count;

    // pend_cnt caps frames in flight so the CRC queue cannot overflow.
    assign s_ready = rst_n && !d_full && (pend_cnt < PW'(CRC_Q_DEPTH));
    assign accept  = s_valid && s_ready;

    // A CRC with no frame waiting for it is dropped and flagged.
    assign unsolicited = crc_in_vld && (q_count == pend_cnt);
    assign q_push      = crc_in_vld && !unsolicited && !q_full;

    sync_fifo_fwft #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata ({s_last, s_data}),
        .pop   (d_pop),
        .rdata ({d_head_last, d_head_data}),
        .full  (d_full),
        .empty (d_empty),
        .count (d_count)
    );

    sync_fifo_fwft #(
        .WIDTH (CRC_WIDTH),
        .DEPTH (CRC_Q_DEPTH)
    ) u_crc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .wdata (crc_in),
        .pop   (q_pop),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_flitEn <= 1'b0;
            crc_dlast  <= 1'b0;
            crc_din    <= '0;
            pend_cnt   <= '0;
            crc_err    <= 1'b0;
            state      <= ST_DATA;
        end else begin
            crc_flitEn <= accept;
            if (accept) begin
                crc_din   <= s_data;
                crc_dlast <= s_last;
            end
            case ({accept && s_last, q_pop})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
            if (unsolicited) begin
                crc_err <= 1'b1;
            end
            state <= state_next;
        end
    end

    // m_data is forced to zero while nothing is offered so reset and idle
    // never expose uninitialised FIFO storage.
    always_comb begin
        state_next = state;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        m_is_crc   = 1'b0;
        d_pop      = 1'b0;
        q_pop      = 1'b0;
        case (state)
            ST_DATA: begin
                m_valid = !d_empty;
                if (!d_empty) begin
                    m_data = d_head_data;
                end
                d_pop = !d_empty && m_ready;
                if (d_pop && d_head_last) begin
                    state_next = ST_CRC;
                end
            end
            ST_CRC: begin
                m_valid  = !q_empty;
                m_last   = 1'b1;
                m_is_crc = 1'b1;
                if (!q_empty) begin
                    m_data = DWIDTH'(q_head);
                end
                q_pop = !q_empty && m_ready;
                if (q_pop) begin
                    state_next = ST_DATA;
                end
            end
            default: state_next = ST_DATA;
        endcase
    end

endmodule

// File: tb/tb_crc_tx_append.sv
// tb/tb_crc_tx_append.sv - self-checking bench for crc_tx_append
module tb_crc_tx_append;

    localparam int DW = 512;
    localparam int CW = 16;

    typedef struct {
        logic          is_crc;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] crc_din;
    logic          crc_dlast;
    logic          crc_flitEn;
    logic [CW-1:0] crc_in = '0;
    logic          crc_in_vld = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          m_is_crc;
    logic          crc_err;

    int errors = 0;
    int checks = 0;

    logic          mr_random = 1'b0;
    logic          mr_level = 1'b0;
    logic          use_fixed = 1'b0;
    logic [CW-1:0] fixed_crc = 16'h1234;
    int            inject_req = 0;
    int            inject_done = 0;

    beat_t         expq[$];
    logic [CW-1:0] macc = '0;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_data = '0;
    int            out_beats = 0;
    logic [CW-1:0] last_crc_seen = '0;

    logic [CW-1:0] gq[$];
    int            gdue[$];
    logic [CW-1:0] gacc = '0;
    int            gcyc = 0;
    int            flit_cnt = 0;
    int            dlast_cnt = 0;
    int            dlast_at_flit = 0;

    crc_tx_append #(
        .DWIDTH      (DW),
        .CRC_WIDTH   (CW),
        .FIFO_DEPTH  (32),
        .CRC_Q_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .crc_din    (crc_din),
        .crc_dlast  (crc_dlast),
        .crc_flitEn (crc_flitEn),
        .crc_in     (crc_in),
        .crc_in_vld (crc_in_vld),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .m_is_crc   (m_is_crc),
        .crc_err    (crc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stand-in CRC: rotate the accumulator, then xor in every 16-bit lane.
    function automatic logic [CW-1:0] fold(input logic [CW-1:0] acc, input logic [DW-1:0] d);
        logic [CW-1:0] r;
        r = {acc[CW-2:0], acc[CW-1]};
        for (int i = 0; i < DW / CW; i++) begin
            r = r ^ d[i*CW +: CW];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // m_ready driver: fixed level or random per cycle.
    always @(negedge clk) begin
        #1;
        m_ready = mr_random ? ($urandom_range(0, 1) == 1) : mr_level;
    end

    // Generator model: consumes the feed and returns one CRC per frame after a random latency.
    always @(negedge clk) begin
        int due;
        #1;
        gcyc++;
        if (!rst_n) begin
            gq.delete();
            gdue.delete();
            gacc = '0;
            crc_in_vld = 1'b0;
        end else begin
            if (crc_flitEn) begin
                flit_cnt++;
                gacc = fold(gacc, crc_din);
                if (crc_dlast) begin
                    dlast_cnt++;
                    dlast_at_flit = flit_cnt;
                    due = gcyc + (use_fixed ? 3 : $urandom_range(1, 6));
                    if (gdue.size() > 0 && due <= gdue[$]) due = gdue[$] + 1;
                    gq.push_back(use_fixed ? fixed_crc : gacc);
                    gdue.push_back(due);
                    gacc = '0;
                end
            end
            if (inject_req != inject_done) begin
                crc_in_vld = 1'b1;
                crc_in = 16'hDEAD;
                inject_done++;
            end else if (gdue.size() > 0 && gdue[0] <= gcyc) begin
                crc_in_vld = 1'b1;
                crc_in = gq.pop_front();
                void'(gdue.pop_front());
            end else begin
                crc_in_vld = 1'b0;
            end
        end
    end

    // Reference model and output checker: every accepted frame must come out
    // in order, followed by exactly one CRC beat carrying the frame's CRC.
    always @(negedge clk) begin
        beat_t b;
        beat_t e;
        #2;
        if (!rst_n) begin
            expq.delete();
            macc = '0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, hold_data);
            end
            if (s_valid && s_ready) begin
                b.is_crc = 1'b0;
                b.data = s_data;
                expq.push_back(b);
                macc = fold(macc, s_data);
                if (s_last) begin
                    b.is_crc = 1'b1;
                    b.data = DW'(use_fixed ? fixed_crc : macc);
                    expq.push_back(b);
                    macc = '0;
                end
            end
            if (m_valid && m_ready) begin
                out_beats++;
                chk("beat_expected", expq.size() != 0, 1'b1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("out_data", m_data, e.data);
                    chk("out_last", m_last, e.is_crc);
                    chk("out_is_crc", m_is_crc, e.is_crc);
                    if (m_is_crc) last_crc_seen = m_data[CW-1:0];
                end
            end
            hold = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    // Called at negedge; returns at the following negedge after acceptance.
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        logic accepted;
        accepted = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        for (int n = 0; n < 3000 && !accepted; n++) begin
            #2;
            accepted = s_ready;
            @(negedge clk);
        end
        chk("send_accept", accepted, 1'b1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            #3;
            done = (expq.size() == 0) && !m_valid;
        end
        chk("drain_done", done, 1'b1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b0);
        chk({tag, "_flitEn"}, crc_flitEn, 1'b0);
        chk({tag, "_dlast"}, crc_dlast, 1'b0);
        chk({tag, "_din"}, crc_din, '0);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_last"}, m_last, 1'b0);
        chk({tag, "_m_is_crc"}, m_is_crc, 1'b0);
        chk({tag, "_m_data"}, m_data, '0);
        chk({tag, "_crc_err"}, crc_err, 1'b0);
    endtask

    initial begin
        int base_out;
        int base_flit;
        int base_dlast;
        int len;
        logic found;
        logic [DW-1:0] a5;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        mr_level = 1'b1;
        @(negedge clk);

        // Single 1-beat frame with a fixed generator result
        use_fixed = 1'b1;
        base_out = out_beats;
        a5 = {(DW / 8){8'hA5}};
        send_beat(a5, 1'b1);
        s_valid = 1'b0;
        drain();
        chk("t1_crc_value", last_crc_seen, 16'h1234);
        chk("t1_beats", out_beats - base_out, 2);
        use_fixed = 1'b0;

        // 3-beat frame held off by m_ready for 10 cycles
        mr_level = 1'b0;
        base_out = out_beats;
        base_flit = flit_cnt;
        base_dlast = dlast_cnt;
        for (int i = 0; i < 3; i++) send_beat(rand_beat(), i == 2);
        s_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        chk("t2_valid_held", m_valid, 1'b1);
        @(negedge clk);
        mr_level = 1'b1;
        drain();
        chk("t2_beats", out_beats - base_out, 4);
        chk("t2_flits", flit_cnt - base_flit, 3);
        chk("t2_dlasts", dlast_cnt - base_dlast, 1);
        chk("t2_dlast_on_third", dlast_at_flit - base_flit, 3);

        // Backlog of CRC_Q_DEPTH frames throttles the input
        mr_level = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(rand_beat(), 1'b1);
        s_valid = 1'b1;
        s_data = rand_beat();
        s_last = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        chk("t3_sready_low", s_ready, 1'b0);
        @(negedge clk);
        mr_level = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            #2;
            if (m_valid && m_ready && m_is_crc) begin
                found = 1'b1;
            end else begin
                chk("t3_sready_held", s_ready, 1'b0);
                @(negedge clk);
            end
        end
        chk("t3_crc_handshake", found, 1'b1);
        @(negedge clk);
        #2;
        chk("t3_sready_rise", s_ready, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        drain();

        // Data FIFO fill, then random m_ready on the rest of a 40-beat frame
        mr_level = 1'b0;
        base_out = out_beats;
        for (int i = 0; i < 32; i++) send_beat(rand_beat(), 1'b0);
        s_data = rand_beat();
        s_last = 1'b0;
        #2;
        chk("t4_full_sready", s_ready, 1'b0);
        @(negedge clk);
        mr_random = 1'b1;
        for (int i = 32; i < 40; i++) send_beat(rand_beat(), i == 39);
        s_valid = 1'b0;
        drain();
        chk("t4_beats", out_beats - base_out, 41);

        // Random frames, gaps and back-pressure
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) send_beat(rand_beat(), b == len - 1);
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        mr_random = 1'b0;
        mr_level = 1'b1;

        // Reset during the 2nd beat of a frame
        send_beat(rand_beat(), 1'b0);
        s_data = rand_beat();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base_out = out_beats;
        send_beat(rand_beat(), 1'b0);
        send_beat(rand_beat(), 1'b1);
        s_valid = 1'b0;
        drain();
        chk("t6_beats", out_beats - base_out, 3);

        // Unsolicited CRC
        #2;
        chk("t7_err_before", crc_err, 1'b0);
        @(negedge clk);
        inject_req++;
        @(negedge clk);
        #2;
        chk("t7_err_set", crc_err, 1'b1);
        @(negedge clk);
        base_out = out_beats;
        for (int i = 0; i < 3; i++) send_beat(rand_beat(), i == 2);
        s_valid = 1'b0;
        drain();
        chk("t7_beats", out_beats - base_out, 4);
        #2;
        chk("t7_err_sticky", crc_err, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
